alk_sp_seq: RTL and testbench

ALK_SP_SEQ -- requirements
Module: alk_sp_seq

---
 rtl/alk_sp_seq.sv | 81 ++++++++
 tb/tb_alk_sp_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alk_sp_seq.sv
// rtl/alk_sp_seq.sv - S/P latch and shift sequencer for the ROT micro-op field
// Moore sequencer: each S/P-class op expands into a fixed or counted run of load/shift steps.
module alk_sp_seq #(
    parameter int CNT_W = 5
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic [5:0]       rot_h,
    input  logic             rot_vld_h,
    input  logic             stall_h,
    input  logic [CNT_W-1:0] sc_h,
    output logic             modsp_l,
    output logic             busy_h,
    output logic             ld_s_h,
    output logic             ld_p_h,
    output logic             shift_h,
    output logic             shift_last_h,
    output logic             done_h
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_S = 3'd1,
        LOAD_P = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             two_load;

    logic rot_s_p;
    logic rot_s_only;
    logic rot_shift;

    assign rot_s_p    = (rot_h == 6'h27) || (rot_h == 6'h2F);
    assign rot_s_only = (rot_h == 6'h2D) || (rot_h == 6'h3D);
    assign rot_shift  = (rot_h == 6'h3B) || (rot_h == 6'h3F);
    assign modsp_l    = ~(rot_s_p | rot_s_only | rot_shift);

    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state    <= IDLE;
            cnt      <= '0;
            two_load <= 1'b0;
        end else if (!stall_h) begin
            case (state)
                IDLE: begin
                    // Non-S/P ROT codes are accepted but fall straight through as no-ops.
                    if (rot_vld_h) begin
                        if (rot_s_p || rot_s_only) begin
                            state    <= LOAD_S;
                            two_load <= rot_s_p;
                        end else if (rot_shift) begin
                            cnt   <= sc_h;
                            state <= (sc_h == '0) ? DONE : SHIFT;
                        end
                    end
                end
                LOAD_S: state <= two_load ? LOAD_P : DONE;
                LOAD_P: state <= DONE;
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Enables come straight from the registered state so reset clears them without waiting for a clock.
    assign busy_h       = (state != IDLE);
    assign ld_s_h       = (state == LOAD_S) && !stall_h;
    assign ld_p_h       = (state == LOAD_P) && !stall_h;
    assign shift_h      = (state == SHIFT) && !stall_h;
    assign shift_last_h = (state == SHIFT) && (cnt == CNT_W'(1)) && !stall_h;
    assign done_h       = (state == DONE) && !stall_h;

endmodule

// File: tb/tb_alk_sp_seq.sv
// tb/tb_alk_sp_seq.sv - self-checking bench for alk_sp_seq
// Reference model: each accepted op becomes a queue of pending steps, one consumed per unstalled cycle.
module tb_alk_sp_seq;

    localparam int CNT_W = 5;
    localparam int ST_LS  = 0;
    localparam int ST_LP  = 1;
    localparam int ST_SH  = 2;
    localparam int ST_SHL = 3;
    localparam int ST_DN  = 4;
    localparam int ST_NONE = 9;

    logic             clk_h = 1'b0;
    logic             reset_h;
    logic [5:0]       rot_h;
    logic             rot_vld_h;
    logic             stall_h;
    logic [CNT_W-1:0] sc_h;
    logic             modsp_l;
    logic             busy_h;
    logic             ld_s_h;
    logic             ld_p_h;
    logic             shift_h;
    logic             shift_last_h;
    logic             done_h;

    int checks = 0;
    int errors = 0;
    int q[$];
    int shift_seen;
    int done_seen;

    alk_sp_seq #(.CNT_W(CNT_W)) dut (
        .clk_h       (clk_h),
        .reset_h     (reset_h),
        .rot_h       (rot_h),
        .rot_vld_h   (rot_vld_h),
        .stall_h     (stall_h),
        .sc_h        (sc_h),
        .modsp_l     (modsp_l),
        .busy_h      (busy_h),
        .ld_s_h      (ld_s_h),
        .ld_p_h      (ld_p_h),
        .shift_h     (shift_h),
        .shift_last_h(shift_last_h),
        .done_h      (done_h)
    );

    always #5 clk_h = ~clk_h;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_sp(input logic [5:0] r);
        logic [5:0] codes [6];
        codes = '{6'h27, 6'h2D, 6'h2F, 6'h3B, 6'h3D, 6'h3F};
        foreach (codes[i]) if (codes[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs(input logic [5:0] r, input logic s);
        int f;
        f = (q.size() > 0) ? q[0] : ST_NONE;
        check("modsp_l", modsp_l, !is_sp(r));
        check("busy_h", busy_h, q.size() > 0);
        check("ld_s_h", ld_s_h, !s && f == ST_LS);
        check("ld_p_h", ld_p_h, !s && f == ST_LP);
        check("shift_h", shift_h, !s && (f == ST_SH || f == ST_SHL));
        check("shift_last_h", shift_last_h, !s && f == ST_SHL);
        check("done_h", done_h, !s && f == ST_DN);
    endtask

    // One clock cycle: drive on the falling edge, check, then advance the model to the next rising edge.
    task automatic step(input logic [5:0] r, input logic v, input logic s, input logic [CNT_W-1:0] c);
        @(negedge clk_h);
        rot_h = r; rot_vld_h = v; stall_h = s; sc_h = c;
        #1;
        check_outputs(r, s);
        if (shift_h) shift_seen++;
        if (done_h) done_seen++;
        if (q.size() > 0) begin
            if (!s) void'(q.pop_front());
        end else if (v && !s && is_sp(r)) begin
            if (r == 6'h27 || r == 6'h2F) begin
                q.push_back(ST_LS); q.push_back(ST_LP);
            end else if (r == 6'h2D || r == 6'h3D) begin
                q.push_back(ST_LS);
            end else begin
                for (int i = 0; i < int'(c); i++) q.push_back((i == int'(c) - 1) ? ST_SHL : ST_SH);
            end
            q.push_back(ST_DN);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(6'h00, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        reset_h = 1'b1; rot_h = 6'h00; rot_vld_h = 1'b0; stall_h = 1'b0; sc_h = '0;
        #1;
        check_outputs(6'h00, 1'b0);
        @(negedge clk_h);
        reset_h = 1'b0;

        // ROT 27: ld_s, ld_p, done at +1..+3
        step(6'h27, 1'b1, 1'b0, 5'd0);
        idle_steps(4);
        // ROT 3B with sc=4 and sc=0
        step(6'h3B, 1'b1, 1'b0, 5'd4);
        idle_steps(6);
        step(6'h3B, 1'b1, 1'b0, 5'd0);
        idle_steps(2);
        // ROT 3F sc=3, stall two cycles mid-shift
        shift_seen = 0; done_seen = 0;
        step(6'h3F, 1'b1, 1'b0, 5'd3);
        step(6'h00, 1'b0, 1'b0, 5'd9);
        step(6'h00, 1'b0, 1'b1, 5'd9);
        step(6'h00, 1'b0, 1'b1, 5'd9);
        idle_steps(4);
        check("stall_shift_count", shift_seen, 3);
        check("stall_done_count", done_seen, 1);
        // non-S/P op and full sweep of the decode
        step(6'h15, 1'b1, 1'b0, 5'd7);
        idle_steps(1);
        for (int r = 0; r < 64; r++) step(6'(r), 1'b0, 1'b0, 5'd0);
        // 2D held valid: one op per accept, re-accepted on first IDLE cycle
        done_seen = 0;
        for (int i = 0; i < 9; i++) step(6'h2D, 1'b1, 1'b0, 5'd0);
        idle_steps(3);
        check("held_2d_done_count", done_seen, 3);
        // max count
        shift_seen = 0;
        step(6'h3F, 1'b1, 1'b0, 5'd31);
        idle_steps(34);
        check("max_shift_count", shift_seen, 31);

        // randomized traffic, sc_h and rot_h keep changing during ops
        for (int i = 0; i < 2500; i++) begin
            logic [5:0] r;
            logic [CNT_W-1:0] c;
            r = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'({6'h27, 6'h2D, 6'h2F, 6'h3B, 6'h3D, 6'h3F} >> (6 * $urandom_range(0, 5)));
            case ($urandom_range(0, 3))
                0: c = '0;
                1: c = '1;
                default: c = CNT_W'($urandom_range(0, 8));
            endcase
            step(r, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 4) == 0), c);
        end
        idle_steps(40);

        // async reset after 10 shifts of a 31-step op
        step(6'h3B, 1'b1, 1'b0, 5'd31);
        for (int i = 0; i < 10; i++) step(6'h00, 1'b0, 1'b0, 5'd0);
        @(posedge clk_h);
        #2 reset_h = 1'b1;
        #1;
        q.delete();
        check_outputs(6'h00, 1'b0);
        @(negedge clk_h);
        reset_h = 1'b0;
        step(6'h2D, 1'b1, 1'b0, 5'd0);
        idle_steps(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
